// File: rtl/pipe_credit_pkg.sv
// Shared constants and helpers for the pipeline credit/output-buffer blocks.
package pipe_credit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned MAX_DEPTH     = 64;

    // Width needed to hold a credit count in 0..depth.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_credit_counter.sv
// Saturating credit counter: resets full, dec consumes a credit, inc returns one.
module pipe_credit_counter
    import pipe_credit_pkg::*;
#(
    parameter int unsigned  DEPTH = DEFAULT_DEPTH,
    localparam int unsigned CW    = credit_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          nonzero
);

    logic [CW-1:0] count_q, count_d;

    // Simultaneous inc/dec cancel; guards keep the count inside 0..DEPTH.
    always_comb begin
        count_d = count_q;
        if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end else if (inc && !dec && (count_q != CW'(DEPTH))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CW'(DEPTH);
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);

endmodule

// File: rtl/pipe_credit_fifo.sv
// Credit-controlled output FIFO behind a valid-only pipeline.
// Optional same-cycle bypass when empty: define PIPE_CREDIT_FIFO_BYPASS_EN.
module pipe_credit_fifo
    import pipe_credit_pkg::*;
#(
    parameter int unsigned  WIDTH = DEFAULT_WIDTH,
    parameter int unsigned  DEPTH = DEFAULT_DEPTH,
    localparam int unsigned CW    = credit_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             pipe_valid,
    input  logic [WIDTH-1:0] pipe_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    credits,
    output logic             overflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_check
        $error("pipe_credit_fifo: DEPTH out of range");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             fifo_empty, fifo_full;
    logic             fifo_push, fifo_pop;
    logic             bypass_take;
    logic             issue_fire, out_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));

`ifdef PIPE_CREDIT_FIFO_BYPASS_EN
    // Empty FIFO forwards the arriving result straight to the output.
    assign out_valid   = !fifo_empty || pipe_valid;
    assign out_data    = fifo_empty ? pipe_data : mem_q[rd_ptr_q];
    assign bypass_take = fifo_empty && pipe_valid && out_ready;
`else
    assign out_valid   = !fifo_empty;
    assign out_data    = mem_q[rd_ptr_q];
    assign bypass_take = 1'b0;
`endif

    assign issue_fire = issue_valid && issue_ready;
    assign out_fire   = out_valid && out_ready;
    assign fifo_pop   = out_ready && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_push  = pipe_valid && !bypass_take && (!fifo_full || fifo_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (fifo_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (fifo_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (pipe_valid && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; out_data is don't-care while empty.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= pipe_data;
        end
    end

    pipe_credit_counter #(
        .DEPTH(DEPTH)
    ) u_credits (
        .clk    (clk),
        .rst_n  (rst_n),
        .dec    (issue_fire),
        .inc    (out_fire),
        .count  (credits),
        .nonzero(issue_ready)
    );

    assign overflow = overflow_q;

endmodule
